// File: rtl/alu_sequencer_if.sv
// Instruction and result channels between an instruction source and alu_sequencer.
// The source holds the master side, the sequencer the slave side.
interface alu_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             instValid;
    logic             instReady;
    logic [2:0]       instOpc;
    logic [1:0]       instDst;
    logic [1:0]       instSrcA;
    logic [1:0]       instSrcB;
    logic             instC;
    logic [WIDTH-1:0] instImm;
    logic             resValid;
    logic             resReady;
    logic [WIDTH-1:0] resData;
    logic             zer;
    logic             neg;

    modport master (
        output instValid, instOpc, instDst, instSrcA, instSrcB, instC, instImm, resReady,
        input  instReady, resValid, resData, zer, neg
    );

    modport slave (
        input  instValid, instOpc, instDst, instSrcA, instSrcB, instC, instImm, resReady,
        output instReady, resValid, resData, zer, neg
    );
endinterface

// File: rtl/alu_sequencer.sv
// Front end for the external combinational ALU: accepts instructions, drives
// registered operands, writes the result back into a 4-entry register file.
//
// state | meaning
// IDLE  | ready for an instruction; operands are latched on accept
// EXEC  | ALU settles on latched operands; writeback at the end of the cycle
// DONE  | result presented on resValid until resReady
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_sequencer_if.slave   bus,
    output logic [WIDTH-1:0] inA,
    output logic [WIDTH-1:0] inB,
    output logic             inC,
    output logic [2:0]       opc,
    input  logic [WIDTH-1:0] outW,
    input  logic             aluZer,
    input  logic             aluNeg,
    input  logic [1:0]       rdSel,
    output logic [WIDTH-1:0] rdData
);
    localparam logic [2:0] OPC_LDI = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic             inst_ready;
    logic             res_valid;
    logic             accept;
    logic             wb;
    logic [1:0]       dst_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] res_data_q;
    logic             zer_q;
    logic             neg_q;
    logic [WIDTH-1:0] regs [4];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end

    always_comb begin
        nxt_state  = state;
        inst_ready = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        wb         = 1'b0;
        case (state)
            IDLE: begin
                inst_ready = 1'b1;
                if (bus.instValid) begin
                    accept    = 1'b1;
                    nxt_state = EXEC;
                end
            end
            EXEC: begin
                wb        = 1'b1;
                nxt_state = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (bus.resReady) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Operands are sampled at accept, so a destination that is also a source
    // sees the value from before this instruction's writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            inA        <= '0;
            inB        <= '0;
            inC        <= 1'b0;
            opc        <= 3'b000;
            dst_q      <= 2'd0;
            imm_q      <= '0;
            res_data_q <= '0;
            zer_q      <= 1'b0;
            neg_q      <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (accept) begin
                inA   <= regs[bus.instSrcA];
                inB   <= regs[bus.instSrcB];
                inC   <= bus.instC;
                opc   <= bus.instOpc;
                dst_q <= bus.instDst;
                imm_q <= bus.instImm;
            end
            if (wb) begin
                if (opc == OPC_LDI) begin
                    regs[dst_q] <= imm_q;
                    res_data_q  <= imm_q;
                    zer_q       <= (imm_q == '0);
                    neg_q       <= imm_q[WIDTH-1];
                end else begin
                    regs[dst_q] <= outW;
                    res_data_q  <= outW;
                    zer_q       <= aluZer;
                    neg_q       <= aluNeg;
                end
            end
        end
    end

    assign bus.instReady = inst_ready;
    assign bus.resValid  = res_valid;
    assign bus.resData   = res_data_q;
    assign bus.zer       = zer_q;
    assign bus.neg       = neg_q;
    assign rdData        = regs[rdSel];
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural stand-in for the ALU.
// Expected results are hand-computed constants.
module tb_alu_sequencer;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] inA, inB, outW, rdData;
    logic             inC, aluZer, aluNeg;
    logic [2:0]       opc;
    logic [1:0]       rdSel;
    int               n_assert = 0;
    int               n_fail   = 0;

    alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .inA    (inA),
        .inB    (inB),
        .inC    (inC),
        .opc    (opc),
        .outW   (outW),
        .aluZer (aluZer),
        .aluNeg (aluNeg),
        .rdSel  (rdSel),
        .rdData (rdData)
    );

    always #5 clk = ~clk;

    // ALU stand-in; opcode 111 returns junk that the sequencer must ignore
    always_comb begin
        case (opc)
            3'b000:  outW = -inA;
            3'b001:  outW = inA + 16'd1;
            3'b010:  outW = inA + inB + {15'd0, inC};
            3'b011:  outW = inA + (inB >> 1);
            3'b100:  outW = inA & inB;
            3'b101:  outW = inA | inB;
            3'b110:  outW = {inA[7:0], inB[7:0]};
            default: outW = 16'hDEAD;
        endcase
        aluZer = (outW == '0);
        aluNeg = outW[WIDTH-1];
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [2:0] o, input logic [1:0] d,
                         input logic [1:0] a, input logic [1:0] b, input logic c,
                         input logic [WIDTH-1:0] imm, input logic [WIDTH-1:0] exp,
                         input logic ez, input logic en);
        int k;
        chk({tag, "_ready"}, {15'd0, bus.instReady}, 16'd1);
        bus.instOpc   = o;
        bus.instDst   = d;
        bus.instSrcA  = a;
        bus.instSrcB  = b;
        bus.instC     = c;
        bus.instImm   = imm;
        bus.instValid = 1'b1;
        bus.resReady  = 1'b1;
        tick();
        bus.instValid = 1'b0;
        chk({tag, "_exec_ready"}, {15'd0, bus.instReady}, 16'd0);
        k = 0;
        while (!bus.resValid && k < 8) begin
            tick();
            k++;
        end
        chk({tag, "_latency"}, k[WIDTH-1:0], 16'd1);
        chk({tag, "_data"}, bus.resData, exp);
        chk({tag, "_zer"}, {15'd0, bus.zer}, {15'd0, ez});
        chk({tag, "_neg"}, {15'd0, bus.neg}, {15'd0, en});
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.instValid = 1'b0;
        bus.instOpc   = 3'b000;
        bus.instDst   = 2'd0;
        bus.instSrcA  = 2'd0;
        bus.instSrcB  = 2'd0;
        bus.instC     = 1'b0;
        bus.instImm   = '0;
        bus.resReady  = 1'b0;
        rdSel         = 2'd0;
        tick();
        tick();
        chk("rst_ready", {15'd0, bus.instReady}, 16'd1);
        chk("rst_valid", {15'd0, bus.resValid}, 16'd0);
        chk("rst_data", bus.resData, 16'h0000);
        chk("rst_flags", {14'd0, bus.zer, bus.neg}, 16'd0);
        chk("rst_inA", inA, 16'h0000);
        chk("rst_inB", inB, 16'h0000);
        chk("rst_ctl", {12'd0, opc, inC}, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdSel = i[1:0];
            #1;
            chk("rst_reg", rdData, 16'h0000);
        end

        issue("ld_r0", 3'b111, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0005, 16'h0005, 1'b0, 1'b0);
        issue("ld_r1", 3'b111, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0003, 16'h0003, 1'b0, 1'b0);
        issue("add", 3'b010, 2'd2, 2'd0, 2'd1, 1'b1, 16'h0000, 16'h0009, 1'b0, 1'b0);
        chk("add_inA_hold", inA, 16'h0005);
        chk("add_inB_hold", inB, 16'h0003);
        chk("add_ctl_hold", {12'd0, opc, inC}, {12'd0, 3'b010, 1'b1});
        rdSel = 2'd2;
        #1;
        chk("add_rd", rdData, 16'h0009);

        issue("neg", 3'b000, 2'd3, 2'd0, 2'd0, 1'b0, 16'h0000, 16'hFFFB, 1'b0, 1'b1);
        issue("inc1", 3'b001, 2'd1, 2'd1, 2'd1, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b0);
        issue("inc2", 3'b001, 2'd1, 2'd1, 2'd1, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0);
        issue("ld_r1b", 3'b111, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0003, 16'h0003, 1'b0, 1'b0);
        issue("shadd", 3'b011, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h0006, 1'b0, 1'b0);
        issue("ld_ffff", 3'b111, 2'd0, 2'd0, 2'd0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        issue("inc_zero", 3'b001, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        issue("ld_8000", 3'b111, 2'd3, 2'd0, 2'd0, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b1);
        issue("ld_zero", 3'b111, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        issue("ld_1234", 3'b111, 2'd0, 2'd0, 2'd0, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0);
        issue("ld_abcd", 3'b111, 2'd1, 2'd0, 2'd0, 1'b0, 16'hABCD, 16'hABCD, 1'b0, 1'b1);
        issue("mix", 3'b110, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h34CD, 1'b0, 1'b0);
        issue("and", 3'b100, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h0204, 1'b0, 1'b0);
        issue("or", 3'b101, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 16'hBBFD, 1'b0, 1'b1);

        // Backpressure: r0+r1 = 0x1234+0xABCD = 0xBE01; competing instruction must be ignored
        bus.instOpc   = 3'b010;
        bus.instDst   = 2'd2;
        bus.instSrcA  = 2'd0;
        bus.instSrcB  = 2'd1;
        bus.instC     = 1'b0;
        bus.instValid = 1'b1;
        bus.resReady  = 1'b0;
        tick();
        bus.instOpc  = 3'b000;
        bus.instSrcA = 2'd3;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {15'd0, bus.resValid}, 16'd1);
            chk("bp_ready", {15'd0, bus.instReady}, 16'd0);
            chk("bp_data", bus.resData, 16'hBE01);
            chk("bp_flags", {14'd0, bus.zer, bus.neg}, 16'd1);
            chk("bp_inA", inA, 16'h1234);
            tick();
        end
        bus.instValid = 1'b0;
        bus.resReady  = 1'b1;
        tick();
        chk("bp_release_valid", {15'd0, bus.resValid}, 16'd0);
        chk("bp_release_ready", {15'd0, bus.instReady}, 16'd1);
        rdSel = 2'd3;
        #1;
        chk("bp_r3_untouched", rdData, 16'h8000);

        // Reset during EXEC drops the pending load
        bus.instOpc   = 3'b111;
        bus.instDst   = 2'd0;
        bus.instImm   = 16'h7777;
        bus.instValid = 1'b1;
        tick();
        bus.instValid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstx_ready", {15'd0, bus.instReady}, 16'd1);
        chk("rstx_valid", {15'd0, bus.resValid}, 16'd0);
        chk("rstx_data", bus.resData, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            rdSel = i[1:0];
            #1;
            chk("rstx_reg", rdData, 16'h0000);
        end
        tick();
        chk("rstx_stays_idle", {15'd0, bus.resValid}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
